gpio_pad_ctrl: RTL and testbench

GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

---
 rtl/gpio_pad_ctrl_pkg.sv | 16 +
 rtl/gpio_pin_filter.sv | 134 +++++++++++++
 rtl/gpio_pad_ctrl.sv | 61 ++++++
 tb/tb_gpio_pad_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pad_ctrl_pkg.sv
// Shared definitions for the GPIO pad controller slice.
// Holds the default pad count and debounce width, plus the state
// encoding of the per-pin input filter FSM.
package gpio_pad_ctrl_pkg;

  localparam int NGPIO_DEF = 3;
  localparam int DBW_DEF   = 4;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } filt_state_e;

endpackage

// File: rtl/gpio_pin_filter.sv
// Per-pin input path: gating by the registered input enable, 2-flop
// synchroniser, debounce FSM with saturating counter and edge pulses.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   debounce_len  required run of matching samples (0 behaves as 1)
//   pad_din       asynchronous pad input
//   pad_ie        registered pad input enable (gates pad_din)
//   core_din      debounced level
//   core_rise     1-cycle pulse on a debounced 0->1 change
//   core_fall     1-cycle pulse on a debounced 1->0 change
module gpio_pin_filter
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int DBW = DBW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [DBW-1:0] debounce_len,
  input  logic           pad_din,
  input  logic           pad_ie,
  output logic           core_din,
  output logic           core_rise,
  output logic           core_fall
);

  logic           sync_p0;
  logic           sync_p1;
  filt_state_e    state_q;
  filt_state_e    state_d;
  logic [DBW-1:0] cnt_q;
  logic [DBW-1:0] cnt_d;
  logic [DBW-1:0] cnt_inc;
  logic [DBW-1:0] len_eff;
  logic           rise_d;
  logic           fall_d;

  // Stage p0/p1: gated input through the synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pad_din & pad_ie;
      sync_p1 <= sync_p0;
    end
  end

  assign len_eff = (debounce_len == '0) ? DBW'(1) : debounce_len;
  assign cnt_inc = (cnt_q == {DBW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // The commit test looks at the count this sample produces, so a clean
  // edge reaches core_din exactly len_eff samples after leaving the
  // synchroniser; with len_eff == 1 the pending state is skipped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (sync_p1) begin
          if (len_eff == DBW'(1)) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            state_d = PEND_HI;
            cnt_d   = DBW'(1);
          end
        end
      end
      PEND_HI: begin
        if (!sync_p1) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_inc >= len_eff) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      STABLE_HI: begin
        if (!sync_p1) begin
          if (len_eff == DBW'(1)) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            state_d = PEND_LO;
            cnt_d   = DBW'(1);
          end
        end
      end
      PEND_LO: begin
        if (sync_p1) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_inc >= len_eff) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage p2: filter state, counter and edge pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      core_rise <= 1'b0;
      core_fall <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      core_rise <= rise_d;
      core_fall <= fall_d;
    end
  end

  // A pending-low pin still reports high until the fall commits.
  assign core_din = (state_q == STABLE_HI) || (state_q == PEND_LO);

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller for one padring side: registers the core's output
// controls toward the pads and runs one input filter per pad.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   debounce_len        input filter length in cycles (0 behaves as 1)
//   core_dout/oe/ie     core-side output data, output enable, input enable
//   core_din            debounced pad inputs
//   core_rise/fall      1-cycle debounced edge pulses
//   pad_din             asynchronous pad inputs
//   pad_dout/oen/ie     registered pad controls (oen is active-low)
module gpio_pad_ctrl
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int NGPIO = NGPIO_DEF,
  parameter int DBW   = DBW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBW-1:0]   debounce_len,
  input  logic [NGPIO-1:0] core_dout,
  input  logic [NGPIO-1:0] core_oe,
  input  logic [NGPIO-1:0] core_ie,
  output logic [NGPIO-1:0] core_din,
  output logic [NGPIO-1:0] core_rise,
  output logic [NGPIO-1:0] core_fall,
  input  logic [NGPIO-1:0] pad_din,
  output logic [NGPIO-1:0] pad_dout,
  output logic [NGPIO-1:0] pad_oen,
  output logic [NGPIO-1:0] pad_ie
);

  // Stage p0: pad control registers; reset leaves every pad tristated
  always_ff @(posedge clk) begin
    if (reset) begin
      pad_dout <= '0;
      pad_oen  <= '1;
      pad_ie   <= '0;
    end else begin
      pad_dout <= core_dout;
      pad_oen  <= ~core_oe;
      pad_ie   <= core_ie;
    end
  end

  for (genvar gi = 0; gi < NGPIO; gi++) begin : g_pin
    gpio_pin_filter #(
      .DBW (DBW)
    ) u_filter (
      .clk          (clk),
      .reset        (reset),
      .debounce_len (debounce_len),
      .pad_din      (pad_din[gi]),
      .pad_ie       (pad_ie[gi]),
      .core_din     (core_din[gi]),
      .core_rise    (core_rise[gi]),
      .core_fall    (core_fall[gi])
    );
  end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
module tb_gpio_pad_ctrl;

  localparam int NGPIO = 3;
  localparam int DBW   = 4;
  localparam int CMAX  = (1 << DBW) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [DBW-1:0]   debounce_len;
  logic [NGPIO-1:0] core_dout, core_oe, core_ie;
  logic [NGPIO-1:0] core_din, core_rise, core_fall;
  logic [NGPIO-1:0] pad_din;
  logic [NGPIO-1:0] pad_dout, pad_oen, pad_ie;

  int checks = 0;
  int errors = 0;

  // Reference model: pad regs, a 2-deep sample delay line per pin, the
  // debounced level and the length of the current run of samples that
  // disagree with it.
  logic [NGPIO-1:0] m_pad_dout, m_pad_oen, m_pad_ie;
  logic [NGPIO-1:0] m_d0, m_d1;
  logic [NGPIO-1:0] m_level, m_rise, m_fall;
  int               m_run [NGPIO];

  gpio_pad_ctrl #(.NGPIO(NGPIO), .DBW(DBW)) dut (
    .clk          (clk),
    .reset        (reset),
    .debounce_len (debounce_len),
    .core_dout    (core_dout),
    .core_oe      (core_oe),
    .core_ie      (core_ie),
    .core_din     (core_din),
    .core_rise    (core_rise),
    .core_fall    (core_fall),
    .pad_din      (pad_din),
    .pad_dout     (pad_dout),
    .pad_oen      (pad_oen),
    .pad_ie       (pad_ie)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model update for one rising edge, using the inputs held across it.
  task automatic model_edge();
    int len;
    logic [NGPIO-1:0] gated;
    len = (debounce_len == 0) ? 1 : int'(debounce_len);
    if (reset) begin
      m_pad_dout = '0; m_pad_oen = '1; m_pad_ie = '0;
      m_d0 = '0; m_d1 = '0; m_level = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < NGPIO; i++) m_run[i] = 0;
    end else begin
      gated = pad_din & m_pad_ie;
      m_rise = '0; m_fall = '0;
      for (int i = 0; i < NGPIO; i++) begin
        if (m_d1[i] != m_level[i]) begin
          m_run[i] = (m_run[i] < CMAX) ? m_run[i] + 1 : CMAX;
          if (m_run[i] >= len) begin
            m_level[i] = m_d1[i];
            if (m_d1[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_d1 = m_d0;
      m_d0 = gated;
      m_pad_dout = core_dout;
      m_pad_oen  = ~core_oe;
      m_pad_ie   = core_ie;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("pad_dout",  32'(pad_dout),  32'(m_pad_dout));
    chk("pad_oen",   32'(pad_oen),   32'(m_pad_oen));
    chk("pad_ie",    32'(pad_ie),    32'(m_pad_ie));
    chk("core_din",  32'(core_din),  32'(m_level));
    chk("core_rise", 32'(core_rise), 32'(m_rise));
    chk("core_fall", 32'(core_fall), 32'(m_fall));
    chk("rise_fall_excl", 32'(|(core_rise & core_fall)), 32'(0));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    reset = 1'b1; debounce_len = '0;
    core_dout = '0; core_oe = '0; core_ie = '0; pad_din = '0;
    m_pad_dout = 'x; m_pad_oen = 'x; m_pad_ie = 'x; m_d0 = 'x; m_d1 = 'x;
    m_level = 'x; m_rise = 'x; m_fall = 'x;
    for (int i = 0; i < NGPIO; i++) m_run[i] = 0;
    #1;

    // Reset state
    ticks(2);
    chk("reset_pad_oen",   32'(pad_oen),   32'(3'b111));
    chk("reset_pad_dout",  32'(pad_dout),  32'(3'b000));
    chk("reset_pad_ie",    32'(pad_ie),    32'(3'b000));
    chk("reset_core_din",  32'(core_din),  32'(3'b000));
    chk("reset_core_rise", 32'(core_rise), 32'(3'b000));
    chk("reset_core_fall", 32'(core_fall), 32'(3'b000));
    reset = 1'b0;

    // Output controls, one cycle latency
    core_oe = 3'b101; core_dout = 3'b111;
    tick();
    chk("oe_pad_oen",  32'(pad_oen),  32'(3'b010));
    chk("oe_pad_dout", 32'(pad_dout), 32'(3'b111));

    // Clean rising edge on pin 0, length 4
    debounce_len = 4'd4; core_ie = 3'b111;
    ticks(3);
    pad_din[0] = 1'b1;
    ticks(5);
    chk("rise0_early", 32'(core_din[0]), 32'(0));
    tick();
    chk("rise0_din",   32'(core_din[0]),  32'(1));
    chk("rise0_pulse", 32'(core_rise[0]), 32'(1));
    tick();
    chk("rise0_pulse_end", 32'(core_rise[0]), 32'(0));

    // Glitch on pin 1 shorter than the filter
    pad_din[1] = 1'b1;
    ticks(3);
    pad_din[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("glitch1_din",  32'(core_din[1]),  32'(0));
      chk("glitch1_rise", 32'(core_rise[1]), 32'(0));
    end

    // Pin 2 stable high, then input enable removed
    pad_din[2] = 1'b1;
    ticks(10);
    chk("pin2_high", 32'(core_din[2]), 32'(1));
    core_ie[2] = 1'b0;
    tick();
    ticks(5);
    chk("ie2_fall_early", 32'(core_fall[2]), 32'(0));
    tick();
    chk("ie2_fall_pulse", 32'(core_fall[2]), 32'(1));
    chk("ie2_din",        32'(core_din[2]),  32'(0));

    // Reset while pin 0 is pending high
    core_ie = 3'b111; pad_din = 3'b000;
    ticks(12);
    pad_din[0] = 1'b1;
    ticks(4);
    reset = 1'b1;
    tick();
    pad_din[0] = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rstpend_din",   32'(core_din),  32'(0));
      chk("rstpend_pulse", 32'(core_rise | core_fall), 32'(0));
    end
    pad_din[0] = 1'b1;
    ticks(5);
    chk("rstpend_edge_early", 32'(core_din[0]), 32'(0));
    tick();
    chk("rstpend_edge_din",   32'(core_din[0]),  32'(1));
    chk("rstpend_edge_pulse", 32'(core_rise[0]), 32'(1));

    // Length 0: all pins together, 3-cycle latency
    debounce_len = 4'd0; pad_din = 3'b000;
    ticks(8);
    pad_din = 3'b111;
    ticks(2);
    chk("len0_early", 32'(core_din), 32'(3'b000));
    tick();
    chk("len0_din",  32'(core_din),  32'(3'b111));
    chk("len0_rise", 32'(core_rise), 32'(3'b111));
    tick();
    chk("len0_rise_end", 32'(core_rise), 32'(3'b000));

    // Length change while pending: drop from 6 to 2 after 4 samples
    debounce_len = 4'd6; pad_din = 3'b000;
    ticks(10);
    pad_din[1] = 1'b1;
    ticks(6);
    chk("lenchg_pending", 32'(core_din[1]), 32'(0));
    debounce_len = 4'd2;
    tick();
    chk("lenchg_commit", 32'(core_rise[1]), 32'(1));

    // Randomised traffic against the model
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) pad_din = NGPIO'($urandom);
      if ($urandom_range(0, 40) == 0) debounce_len = DBW'($urandom_range(0, 6));
      if ($urandom_range(0, 10) == 0) core_ie = ($urandom_range(0, 3) == 0) ? NGPIO'($urandom) : '1;
      core_dout = NGPIO'($urandom);
      core_oe   = NGPIO'($urandom);
      reset     = ($urandom_range(0, 150) == 0);
      tick();
    end
    reset = 1'b0;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
